// File: rtl/clk_div_pkg.sv
// Shared encodings and standard terminal counts for the clock divider bank.
package clk_div_pkg;

  // Output mode of a divider channel.
  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } ch_mode_e;

  // Default counter / terminal-count width.
  localparam int DEF_CNT_W = 29;

  // Terminal counts for a 100 MHz board clock (wrap period = TC + 1 cycles).
  localparam int unsigned TC_1HZ  = 32'd49_999_999;
  localparam int unsigned TC_2HZ  = 32'd24_999_999;
  localparam int unsigned TC_1KHZ = 32'd49_999;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: wrap counter, shadowed terminal count applied only at
// a period boundary (or while stopped), mode latch and registered outputs.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int                CNT_W  = DEF_CNT_W,
  parameter logic [CNT_W-1:0]  RST_TC = CNT_W'(TC_1HZ)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             tc_load,
  input  logic [CNT_W-1:0] tc_value,
  output logic             divided_clk,
  output logic             tick
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] active_tc_reg;
  logic [CNT_W-1:0] shadow_tc_reg;
  logic             pending_reg;
  ch_mode_e         mode_reg;
  logic             tick_reg;
  logic             div_reg;
  logic             at_tc;
  ch_mode_e         mode_req;

  // Equality only: loads never move active_tc below the running count.
  always_comb begin
    at_tc    = (cnt_reg == active_tc_reg);
    mode_req = ch_mode_e'(mode);
  end

  // Shadow register always takes the newest load; the last of several wins.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      shadow_tc_reg <= RST_TC;
    end else if (tc_load) begin
      shadow_tc_reg <= tc_value;
    end
  end

  // Counter, terminal-count hand-over, mode latch and output registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_reg       <= '0;
      active_tc_reg <= RST_TC;
      pending_reg   <= 1'b0;
      mode_reg      <= MODE_SQUARE;
      tick_reg      <= 1'b0;
      div_reg       <= 1'b0;
    end else if (!en) begin
      // Stopped: hold state, but a pending load applies now so that the
      // next enable starts a clean period with the new count.
      tick_reg <= 1'b0;
      if (mode_reg == MODE_PULSE) begin
        div_reg <= 1'b0;  // pulse output mirrors the (forced-low) tick
      end
      if (pending_reg) begin
        active_tc_reg <= shadow_tc_reg;
        cnt_reg       <= '0;
      end
      pending_reg <= tc_load;
    end else if (at_tc) begin
      // Period boundary: new count and mode take effect here. A load in
      // this same cycle lands in shadow and stays pending for next wrap.
      cnt_reg  <= '0;
      tick_reg <= 1'b1;
      if (pending_reg) begin
        active_tc_reg <= shadow_tc_reg;
      end
      pending_reg <= tc_load;
      mode_reg    <= mode_req;
      if (mode_req == MODE_PULSE) begin
        div_reg <= 1'b1;
      end else if (mode_reg == MODE_SQUARE) begin
        div_reg <= ~div_reg;
      end else begin
        div_reg <= 1'b0;  // freshly entering square mode starts low
      end
    end else begin
      cnt_reg     <= cnt_reg + CNT_ONE;
      tick_reg    <= 1'b0;
      pending_reg <= pending_reg | tc_load;
      if (mode_reg == MODE_PULSE) begin
        div_reg <= 1'b0;
      end
    end
  end

  assign divided_clk = div_reg;
  assign tick        = tick_reg;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent runtime-programmable clock dividers / tick generators
// sharing one terminal-count bus.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int               NUM_CH = 4,
  parameter int               CNT_W  = DEF_CNT_W,
  parameter logic [CNT_W-1:0] RST_TC = CNT_W'(TC_1HZ)
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_mode,
  input  logic [NUM_CH-1:0] tc_load,
  input  logic [CNT_W-1:0]  tc_value,
  output logic [NUM_CH-1:0] divided_clk,
  output logic [NUM_CH-1:0] tick
);

  // One channel per bit; tc_value fans out, tc_load selects the targets.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    clk_div_channel #(
      .CNT_W  (CNT_W),
      .RST_TC (RST_TC)
    ) u_ch (
      .clk_in      (clk_in),
      .rst         (rst),
      .en          (ch_en[gi]),
      .mode        (ch_mode[gi]),
      .tc_load     (tc_load[gi]),
      .tc_value    (tc_value),
      .divided_clk (divided_clk[gi]),
      .tick        (tick[gi])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with RST_TC overridden to 3.
module tb_clk_div_bank;

  logic        clk_in;
  logic        rst;
  logic [3:0]  ch_en;
  logic [3:0]  ch_mode;
  logic [3:0]  tc_load;
  logic [28:0] tc_value;
  logic [3:0]  divided_clk;
  logic [3:0]  tick;

  int n_vec;
  int n_miss;

  typedef struct {
    logic [3:0] en;
    logic [3:0] mode;
    logic [3:0] exp_div;
    logic [3:0] exp_tick;
  } vec_t;

  vec_t vq[$];

  clk_div_bank #(
    .NUM_CH (4),
    .CNT_W  (29),
    .RST_TC (29'd3)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .ch_en       (ch_en),
    .ch_mode     (ch_mode),
    .tc_load     (tc_load),
    .tc_value    (tc_value),
    .divided_clk (divided_clk),
    .tick        (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
    end else begin
      $display("ok   %s[%0d]: %b", name, idx, act);
    end
  endtask

  task automatic add(input logic [3:0] en, input logic [3:0] mode,
                     input logic [3:0] d, input logic [3:0] t, input int reps);
    for (int r = 0; r < reps; r++) vq.push_back('{en, mode, d, t});
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    ch_en   = 4'h0;
    ch_mode = 4'h0;
    tc_load = 4'h0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic       exp_t;
    logic       exp_d;
    n_vec    = 0;
    n_miss   = 0;
    rst      = 1'b1;
    ch_en    = 4'h0;
    ch_mode  = 4'h0;
    tc_load  = 4'h0;
    tc_value = '0;

    // ch0: TC=3, square, freeze, pulse mode, back to square (starts low)
    add(4'h1, 4'h0, 4'h0, 4'h0, 3);
    add(4'h1, 4'h0, 4'h1, 4'h1, 1);
    add(4'h1, 4'h0, 4'h1, 4'h0, 3);
    add(4'h1, 4'h0, 4'h0, 4'h1, 1);
    add(4'h1, 4'h0, 4'h0, 4'h0, 3);
    add(4'h1, 4'h0, 4'h1, 4'h1, 1);
    add(4'h0, 4'h0, 4'h1, 4'h0, 2);
    add(4'h1, 4'h0, 4'h1, 4'h0, 3);
    add(4'h1, 4'h0, 4'h0, 4'h1, 1);
    add(4'h1, 4'h1, 4'h0, 4'h0, 3);
    add(4'h1, 4'h1, 4'h1, 4'h1, 1);
    add(4'h1, 4'h1, 4'h0, 4'h0, 3);
    add(4'h1, 4'h1, 4'h1, 4'h1, 1);
    add(4'h1, 4'h0, 4'h0, 4'h0, 3);
    add(4'h1, 4'h0, 4'h0, 4'h1, 1);
    add(4'h1, 4'h0, 4'h0, 4'h0, 3);
    add(4'h1, 4'h0, 4'h1, 4'h1, 1);

    // Reset state
    step();
    step();
    chk("rst_div", 0, divided_clk, 4'h0);
    chk("rst_tick", 0, tick, 4'h0);
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < vq.size(); i++) begin
      ch_en   = vq[i].en;
      ch_mode = vq[i].mode;
      step();
      chk("tbl_div", i, divided_clk, vq[i].exp_div);
      chk("tbl_tick", i, tick, vq[i].exp_tick);
    end

    // ch1 pulse mode, TC=4 loaded while disabled
    do_reset();
    ch_mode  = 4'b0010;
    tc_value = 29'd4;
    tc_load  = 4'b0010;
    step();
    tc_load = 4'h0;
    step();
    ch_en = 4'b0010;
    for (int k = 1; k <= 15; k++) begin
      step();
      exp_t = (k % 5 == 0);
      chk("pulse_tick", k, tick, {2'b00, exp_t, 1'b0});
      chk("pulse_div", k, divided_clk, {2'b00, exp_t, 1'b0});
    end

    // ch0 TC=9, reload to 2 mid-period
    do_reset();
    tc_value = 29'd9;
    tc_load  = 4'b0001;
    step();
    tc_load = 4'h0;
    step();
    ch_en = 4'b0001;
    exp_d = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_t = (k == 10 || k == 13 || k == 16);
      if (exp_t) exp_d = ~exp_d;
      chk("reload_tick", k, tick, {3'b000, exp_t});
      chk("reload_div", k, divided_clk, {3'b000, exp_d});
      if (k == 4) begin
        tc_value = 29'd2;
        tc_load  = 4'b0001;
      end
      if (k == 5) tc_load = 4'h0;
    end

    // ch2: load on wrap cycle then a second load; last wins
    do_reset();
    ch_en = 4'b0100;
    exp_d = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      exp_t = (k == 4 || k == 8 || k == 16 || k == 24);
      if (exp_t) exp_d = ~exp_d;
      chk("lastwin_tick", k, tick, {1'b0, exp_t, 2'b00});
      chk("lastwin_div", k, divided_clk, {1'b0, exp_d, 2'b00});
      if (k == 3) begin
        tc_value = 29'd5;
        tc_load  = 4'b0100;
      end
      if (k == 4) tc_value = 29'd7;
      if (k == 5) tc_load = 4'h0;
    end

    // ch3: TC=0 gives clk_in/2 with tick stuck high, then freeze
    do_reset();
    tc_value = 29'd0;
    tc_load  = 4'b1000;
    step();
    tc_load = 4'h0;
    step();
    ch_en = 4'b1000;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("tc0_tick", k, tick, 4'b1000);
      chk("tc0_div", k, divided_clk, {(k % 2 == 1), 3'b000});
    end
    ch_en = 4'h0;
    for (int k = 6; k <= 8; k++) begin
      step();
      chk("frz_tick", k, tick, 4'h0);
      chk("frz_div", k, divided_clk, 4'b1000);
    end
    ch_en = 4'b1000;
    step();
    chk("tc0_resume_div", 1, divided_clk, 4'b0000);
    chk("tc0_resume_tick", 1, tick, 4'b1000);
    step();
    chk("tc0_resume_div", 2, divided_clk, 4'b1000);
    chk("tc0_resume_tick", 2, tick, 4'b1000);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_div", 0, divided_clk, 4'h0);
    chk("async_rst_tick", 0, tick, 4'h0);
    step();
    rst     = 1'b0;
    ch_en   = 4'hF;
    ch_mode = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("post_rst_tick", k, tick, (k % 4 == 0) ? 4'hF : 4'h0);
      chk("post_rst_div", k, divided_clk, (k >= 4 && k <= 7) ? 4'hF : 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel, runtime-programmable clock divider and tick generator; successor to the fixed single-channel toggle divider.
- Derives several slow timing signals from the single board clock, e.g. display refresh, keypad scan, lockout timer and blink rate for the digital lock.
- Each channel has its own terminal count, enable and output mode.
- New terminal counts are loaded glitch-free: they take effect only at a period boundary.

Parameters:
- NUM_CH, 4, number of independent divider channels.
- CNT_W, 29, counter and terminal-count width in bits.
- RST_TC, 29'd49_999_999, terminal count every channel uses out of reset (1 Hz square wave at 100 MHz).

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- ch_en  input  NUM_CH  per-channel run enable; 0 freezes the channel.
- ch_mode  input  NUM_CH  per-channel output mode: 0 = square (toggle), 1 = pulse.
- tc_load  input  NUM_CH  one-hot or multi-hot strobe that loads tc_value into the selected channels' shadow registers.
- tc_value  input  CNT_W  new terminal count, unsigned.
- divided_clk  output  NUM_CH  per-channel divided output.
- tick  output  NUM_CH  one-cycle pulse on each counter wrap.

Behaviour:
- Reset (asynchronous, rst=1), per channel:
  - cnt=0, active_tc=RST_TC, shadow_tc=RST_TC, pending=0.
  - divided_clk=0, tick=0.
- Counting, with ch_en=1:
  - If cnt==active_tc: cnt<=0, tick<=1 for exactly one cycle, wrap event.
  - Otherwise cnt<=cnt+1, tick<=0.
  - Wrap period is active_tc+1 cycles.
- Output modes:
  - ch_mode=0: divided_clk toggles on each wrap. Full period is 2*(active_tc+1) cycles, 50% duty.
  - ch_mode=1: divided_clk equals the registered tick, high for 1 of every active_tc+1 cycles.
- Mode change: a change of ch_mode takes effect at the next wrap, latched with active_tc.
  - Entering mode 0 starts with divided_clk=0.
  - divided_clk never glitches mid-period.
- Registered outputs:
  - tick and divided_clk are registered outputs, no combinational path from inputs.
  - tick asserts in the cycle after the one where cnt==active_tc was sampled.
- tc_value=0:
  - Wrap every cycle; tick held high continuously.
  - Mode 0 gives clk_in/2.
  - This setting is legal.
- Loading a terminal count (tc_load[i]=1):
  - shadow_tc[i]<=tc_value, pending[i]<=1.
  - At the next wrap of channel i: active_tc<=shadow_tc, pending<=0.
  - A load in the same cycle as a wrap is captured into shadow and applied at the following wrap, never dropped.
  - Back-to-back loads before a wrap: the last one wins.
- Disabled channel (ch_en[i]=0):
  - cnt, divided_clk and tick hold; tick forced 0.
  - A pending load is applied immediately (next edge), cnt<=0, so re-enable starts a clean period.
  - Re-enable resumes counting from the held or reset cnt.
- active_tc lowered below the current cnt: cannot occur, because loads only apply at wrap or while disabled (cnt=0). The compare is == only, so wrap-around at 2^CNT_W is unreachable.
- Channels are fully independent; simultaneous wraps on all channels are legal.
- rst asserted mid-count clears immediately, with no dependence on clk_in; deassertion is synchronous to clk_in at integration level.

Decomposition:
- Package clk_div_pkg holds:
  - mode encodings MODE_SQUARE=1'b0, MODE_PULSE=1'b1.
  - default CNT_W=29.
  - standard terminal-count constants for 100 MHz: TC_1HZ=49_999_999, TC_2HZ=24_999_999, TC_1KHZ=49_999.
- Sub-module clk_div_channel: one channel (counter, shadow/active TC, pending, mode latch, output regs).
- Top module: generate-loop over NUM_CH and fans out tc_value.

Test Plan:
- Reset with RST_TC overridden to 3, ch_en=4'b0001, mode 0 → ch0 divided_clk period 8 cycles, 50% duty; tick every 4 cycles; other channels stay 0.
- Ch1 mode 1, tc_value=4 loaded while disabled, then enabled → tick/divided_clk high 1 of every 5 cycles; first pulse 5 cycles after enable.
- Ch0 running at TC=9; load tc_value=2 at cnt=4 → current period completes at 10 cycles, then period is 3; no short or extra toggle.
- Load coincident with wrap cycle, then a second load 1 cycle later (values 5 then 7) → after the next wrap the period is 8, i.e. the last load wins.
- tc_value=0, mode 0 → divided_clk = clk_in/2, tick constantly 1; ch_en dropped → outputs freeze, tick=0.
- Assert rst asynchronously mid-period (between edges) → all divided_clk/tick go 0 immediately; after release, periods revert to RST_TC.
